// File: rtl/oxu_pkg.sv
// oxu_pkg: opcode constants, FSM states and opcode decode shared by the opcode transfer unit.
package oxu_pkg;
   localparam logic [2:0] OP_XFER = 3'b000;
   localparam logic [2:0] OP_INC  = 3'b001;
   localparam logic [2:0] OP_SWAP = 3'b010;
   localparam logic [2:0] OP_LOAD = 3'b011;
   localparam logic [2:0] OP_PASS = 3'b1??;

   typedef enum logic [1:0] {IDLE, XFER, LOAD} state_t;
   typedef enum logic [2:0] {K_NONE, K_XFER, K_INC, K_SWAP, K_LOAD, K_PASS} op_kind_t;

   function automatic op_kind_t op_decode(input logic [2:0] op);
      casez (op)
         OP_PASS: return K_PASS;
         OP_XFER: return K_XFER;
         OP_INC:  return K_INC;
         OP_SWAP: return K_SWAP;
         OP_LOAD: return K_LOAD;
         default: return K_NONE;
      endcase
   endfunction
endpackage

// File: rtl/oxu_ram.sv
// oxu_ram: single-port synchronous RAM, DEPTH x DATA_W, registered read output.
module oxu_ram #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic              re,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);
   logic [DATA_W-1:0] mem [2**ADDR_W];

   always_ff @(posedge clk)
      if (we) mem[addr] <= wdata;

   // only the read register resets; array contents survive reset
   always_ff @(posedge clk)
      rdata <= !rst_n ? '0 : re ? mem[addr] : rdata;
endmodule

// File: rtl/opcode_xfer_unit.sv
// opcode_xfer_unit: opcode-driven accumulator/ALU with burst RAM writes and a full-RAM load sweep.
// Build option OXU_ADDR_WRAP_EN: write address wraps at DEPTH-1 instead of ending the transfer with err.
module opcode_xfer_unit
   import oxu_pkg::*;
#(
   parameter int DATA_W    = 16,
   parameter int ADDR_W    = 8,
   parameter int BURST_LEN = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              op_valid,
   output logic              op_ready,
   input  logic [2:0]        opcode,
   input  logic              bloc_xfer,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] accum,
   output logic [DATA_W-1:0] alu_out,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              done,
   output logic              err
);
   localparam int H = DATA_W / 2;

   state_t            state, state_n;
   op_kind_t          kind;
   logic [ADDR_W-1:0] addr;
   logic [7:0]        beat;
   logic              accept, addr_last, burst_end, xfer_end, load_end, we, re;

   always_comb begin
      kind      = op_decode(opcode);
      accept    = op_valid && state == IDLE;
      burst_end = beat == 8'(BURST_LEN - 1);
`ifdef OXU_ADDR_WRAP_EN
      addr_last = 1'b0;
`else
      addr_last = &addr;
`endif
      xfer_end  = state == XFER && (addr_last || (burst_end && !bloc_xfer));
      load_end  = state == LOAD && &addr;
      we        = state == XFER && rst_n;
      re        = state == LOAD;
      op_ready  = state == IDLE;
      state_n   = accept && kind == K_XFER ? XFER :
                  accept && kind == K_LOAD ? LOAD :
                  xfer_end || load_end     ? IDLE : state;
   end

   always_ff @(posedge clk)
      state <= !rst_n ? IDLE : state_n;

   // one address counter serves both the write burst and the load sweep
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         accum    <= '0;
         alu_out  <= '0;
         rd_valid <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
         addr     <= '0;
         beat     <= '0;
      end else begin
         done     <= xfer_end || load_end || (accept && (kind == K_INC || kind == K_SWAP || kind == K_PASS));
         rd_valid <= re;
         addr     <= accept ? '0 : state != IDLE ? addr + 1'b1 : addr;
         beat     <= state == XFER && !burst_end ? beat + 8'd1 : 8'd0;
         accum    <= !accept         ? accum :
                     kind == K_INC   ? accum + 1'b1 :
                     kind == K_SWAP  ? {accum[H-1:0], accum[DATA_W-1:H]} : accum;
         alu_out  <= accept && kind == K_PASS ? accum : alu_out;
`ifndef OXU_ADDR_WRAP_EN
         if (xfer_end && addr_last) err <= 1'b1;
`endif
      end
   end

   oxu_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (we),
      .re    (re),
      .addr  (addr),
      .wdata (data_in),
      .rdata (rd_data)
   );
endmodule

// File: tb/tb_opcode_xfer_unit.sv
// tb_opcode_xfer_unit: table vectors, directed burst/load/reset sequences and random ops vs a behavioural model.
module tb_opcode_xfer_unit;
   localparam int DW = 16, AW = 8, BL = 5, DEPTH = 256;

   logic          clk = 0, rst_n = 0, op_valid = 0, bloc_xfer = 0;
   logic [2:0]    opcode = 0;
   logic [DW-1:0] data_in = 0;
   logic          op_ready, rd_valid, done, err;
   logic [DW-1:0] accum, alu_out, rd_data;

   int            checks = 0, errors = 0;
   logic [DW-1:0] m_accum = 0, m_alu = 0;
   logic [DW-1:0] m_ram [DEPTH];
   logic          m_err = 0;

   typedef struct {logic [2:0] op; logic [DW-1:0] acc; logic [DW-1:0] alu;} vec_t;
   vec_t vt [8];

   opcode_xfer_unit #(.DATA_W(DW), .ADDR_W(AW), .BURST_LEN(BL)) dut (
      .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready), .opcode(opcode),
      .bloc_xfer(bloc_xfer), .data_in(data_in), .accum(accum), .alu_out(alu_out),
      .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic do_reset;
      rst_n = 0; op_valid = 0; bloc_xfer = 0;
      tick;
      m_accum = 0; m_alu = 0; m_err = 0;
      chk("rst_accum", accum, 0);
      chk("rst_alu", alu_out, 0);
      chk("rst_rd_data", rd_data, 0);
      chk("rst_rd_valid", rd_valid, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_ready", op_ready, 1);
      rst_n = 1;
      tick;
      chk("rel_ready", op_ready, 1);
      chk("rel_done", done, 0);
   endtask

   task automatic do_op(input logic [2:0] op);
      op_valid = 1; opcode = op;
      tick;
      op_valid = 0;
      if (op[2]) m_alu = m_accum;
      else if (op == 3'b001) m_accum = m_accum + 1;
      else if (op == 3'b010) m_accum = {m_accum[7:0], m_accum[15:8]};
      chk("op_done", done, 1);
      chk("op_accum", accum, m_accum);
      chk("op_alu", alu_out, m_alu);
      chk("op_ready", op_ready, 1);
   endtask

   task automatic run_xfer(input int nb, input logic [DW-1:0] base, input bit rnd);
      int w = 0;
      bit last = 0;
      logic [AW-1:0] a = 0;
      op_valid = 1; opcode = 3'b000; bloc_xfer = 0;
      tick;
      chk("xfer_start_ready", op_ready, 0);
      chk("xfer_start_done", done, 0);
      while (!last) begin
         data_in   = rnd ? DW'($urandom) : base + DW'(w);
         bloc_xfer = (w % BL == BL - 1) ? (w / BL < nb - 1) : 1'($urandom);
         op_valid  = 1'($urandom);
         opcode    = 3'($urandom);
         last      = w == nb * BL - 1;
`ifndef OXU_ADDR_WRAP_EN
         if (a == AW'(DEPTH - 1)) begin
            last = 1;
            m_err = 1;
         end
`endif
         m_ram[a] = data_in;
         a++;
         tick;
         w++;
         chk("xfer_done", done, last);
         chk("xfer_ready", op_ready, last);
      end
      op_valid = 0; bloc_xfer = 0;
      chk("xfer_err", err, m_err);
      tick;
      chk("xfer_done_pulse", done, 0);
   endtask

   task automatic run_load;
      op_valid = 1; opcode = 3'b011;
      tick;
      op_valid = 0;
      chk("load_start_valid", rd_valid, 0);
      chk("load_start_ready", op_ready, 0);
      for (int i = 0; i < DEPTH; i++) begin
         tick;
         chk("load_valid", rd_valid, 1);
         chk("load_data", rd_data, m_ram[i]);
         chk("load_done", done, i == DEPTH - 1);
      end
      tick;
      chk("load_end_valid", rd_valid, 0);
      chk("load_end_done", done, 0);
      chk("load_end_ready", op_ready, 1);
   endtask

   initial begin
      vt[0] = '{3'b001, 16'h0001, 16'h0000};
      vt[1] = '{3'b001, 16'h0002, 16'h0000};
      vt[2] = '{3'b100, 16'h0002, 16'h0002};
      vt[3] = '{3'b010, 16'h0200, 16'h0002};
      vt[4] = '{3'b111, 16'h0200, 16'h0200};
      vt[5] = '{3'b010, 16'h0002, 16'h0200};
      vt[6] = '{3'b001, 16'h0003, 16'h0200};
      vt[7] = '{3'b101, 16'h0003, 16'h0003};

      do_reset;
      for (int i = 0; i < 8; i++) begin
         do_op(vt[i].op);
         chk("tbl_accum", accum, vt[i].acc);
         chk("tbl_alu", alu_out, vt[i].alu);
         tick;
         chk("tbl_done_clear", done, 0);
      end

      op_valid = 1; opcode = 3'b001;
      for (int i = 0; i < 16'h12A8; i++) tick;
      op_valid = 0;
      m_accum = 16'h12AB;
      chk("inc_run_accum", accum, 16'h12AB);
      tick;
      do_op(3'b010);
      chk("swap_accum", accum, 16'hAB12);
      do_op(3'b110);
      chk("pass_alu", alu_out, 16'hAB12);

      repeat (100) begin
         case ($urandom_range(0, 2))
            0:       do_op(3'b001);
            1:       do_op(3'b010);
            default: do_op(3'(4 + $urandom_range(0, 3)));
         endcase
         if ($urandom_range(0, 1) == 1) begin
            tick;
            chk("rand_gap_done", done, 0);
         end
      end

      run_xfer(52, 16'h0, 1);
      do_op(3'b001);
      chk("err_sticky", err, m_err);
      do_reset;

      run_xfer(1, 16'hA0, 0);
      run_xfer(2, 16'hA0, 0);
      run_load;

      repeat (3) run_xfer($urandom_range(1, 4), 16'h0, 1);

      op_valid = 1; opcode = 3'b000;
      tick;
      op_valid = 0;
      for (int w = 0; w < 3; w++) begin
         data_in = 16'hC0 + 16'(w);
         m_ram[w] = data_in;
         tick;
         chk("mid_done", done, 0);
      end
      data_in = 16'hCC;
      do_reset;
      run_load;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/opcode_xfer_unit.md
OPCODE_XFER_UNIT -- requirements
Module: opcode_xfer_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 16, datapath width; even values only, >= 4.
REQ-002 SHALL have parameter ADDR_W, default 8, RAM address width; DEPTH = 2**ADDR_W.
REQ-003 SHALL have parameter BURST_LEN, default 5, write beats per burst; range 1..255.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  synchronous active-low reset.
REQ-006 SHALL have port op_valid  input  1  opcode offered.
REQ-007 SHALL have port op_ready  output  1  unit can accept an opcode.
REQ-008 SHALL have port opcode  input  3  operation code, casez-decoded.
REQ-009 SHALL have port bloc_xfer  input  1  continue-transfer request, sampled at burst boundaries.
REQ-010 SHALL have port data_in  input  DATA_W  write data for block transfer.
REQ-011 SHALL have port accum  output  DATA_W  accumulator register.
REQ-012 SHALL have port alu_out  output  DATA_W  registered ALU result.
REQ-013 SHALL have port rd_data  output  DATA_W  load-sweep read data.
REQ-014 SHALL have port rd_valid  output  1  rd_data valid this cycle.
REQ-015 SHALL have port done  output  1  one-cycle pulse when an accepted operation completes.
REQ-016 SHALL have port err  output  1  sticky address-overflow flag.

Function
REQ-017 SHALL accept an opcode on the cycle op_valid and op_ready are both 1; op_ready = 1 only in IDLE.
REQ-018 SHALL implement FSM states IDLE, XFER, LOAD; 3'b000 -> XFER, 3'b011 -> LOAD, all others stay in IDLE.
REQ-019 SHALL, for opcode 3'b1??, load alu_out <= accum; done pulses next cycle.
REQ-020 SHALL, for 3'b001, set accum <= accum + 1 modulo 2**DATA_W; done next cycle.
REQ-021 SHALL, for 3'b010, swap accum upper and lower halves; done next cycle.
REQ-022 SHALL, in XFER, write data_in to RAM[wr_addr] every cycle, increment wr_addr, and count beats; wr_addr starts at 0 on each XFER acceptance.
REQ-023 SHALL, after BURST_LEN beats, sample bloc_xfer: 1 starts another burst on the next cycle with no gap; 0 returns to IDLE with done.
REQ-024 SHALL, in LOAD, read RAM[i] for i = 0..DEPTH-1; rd_data/rd_valid appear one cycle after each address (1-cycle read latency); done coincides with the last rd_valid.
REQ-025 SHALL hold bloc_xfer irrelevant outside burst boundaries and ignore op_valid outside IDLE.

Reset
REQ-026 SHALL, on rst_n = 0 at a clock edge, force state IDLE, accum 0, alu_out 0, rd_data 0, rd_valid 0, done 0, err 0, wr_addr 0, beat count 0; op_ready = 1 from the first cycle after rst_n releases.
REQ-027 SHALL abort any XFER or LOAD in progress on reset without a done pulse; RAM contents are not cleared.

Configuration
REQ-028 SHALL honour macro OXU_ADDR_WRAP_EN: defined -> wr_addr wraps DEPTH-1 -> 0 and err stays 0; undefined -> a write at DEPTH-1 is the final beat, XFER ends with done, err sets and holds until reset.

Structure
REQ-029 SHALL place opcode constants (OP_XFER, OP_INC, OP_SWAP, OP_LOAD, OP_PASS pattern) and the state enum in package oxu_pkg.
REQ-030 SHALL instantiate one sub-module oxu_ram: single-port synchronous RAM, DEPTH x DATA_W, registered read.

Verification
REQ-031 SHALL cover: reset, opcode 3'b001 twice -> accum = 16'h0002, two done pulses.
REQ-032 SHALL cover: accum = 16'h12AB, opcode 3'b010 -> accum = 16'hAB12; then 3'b110 -> alu_out = 16'hAB12.
REQ-033 SHALL cover: opcode 3'b000, bloc_xfer = 0, data_in = 16'hA0+beat -> RAM[0..4] = A0..A4, done at cycle 5, op_ready 0 throughout.
REQ-034 SHALL cover: bloc_xfer = 1 for first boundary only -> 10 writes, RAM[9] = 16'hA9, no idle gap between bursts.
REQ-035 SHALL cover: opcode 3'b011 after REQ-034 -> rd_data sequence A0..A9 then RAM contents, 256 rd_valid cycles, done on the last.
REQ-036 SHALL cover: rst_n low mid-XFER at beat 3 -> no done, outputs at reset values next cycle; and with macro undefined, 52 bursts -> err = 1 after write at address 255.
